// File: rtl/md_sched_pkg.sv
// Shared definitions for the multiply/divide sequencer: command codes and FSM states.
package md_sched_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6,
      MD_RSVD  = 3'd7
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   localparam logic [31:0] INT_MIN = 32'h8000_0000;
   localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

   function automatic int max_int(input int x, input int y);
      return (x > y) ? x : y;
   endfunction

endpackage

// File: rtl/md_sched_calc.sv
// Combinational multiply/divide datapath; the result is latched by md_sched at start time.
module md_sched_calc
   import md_sched_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] hi_n,
   output logic [31:0] lo_n,
   output logic        wr_en
);

   logic signed [63:0] a_sx, b_sx, prod_s;
   logic        [63:0] prod_u;
   logic signed [31:0] a_s, b_s, quot_s, rem_s;
   logic        [31:0] b_safe, quot_u, rem_u;
   logic               div_zero, div_ovf;
   md_op_e             op_e;

   assign op_e     = md_op_e'(op);
   assign a_sx     = {{32{a[31]}}, a};
   assign b_sx     = {{32{b[31]}}, b};
   assign prod_s   = a_sx * b_sx;
   assign prod_u   = {32'd0, a} * {32'd0, b};

   // Divisor forced to 1 on zero so the divider never sees an undefined operation.
   assign div_zero = (b == 32'd0);
   assign div_ovf  = (a == INT_MIN) && (b == NEG_ONE);
   assign b_safe   = div_zero ? 32'd1 : b;
   assign a_s      = a;
   assign b_s      = b_safe;
   assign quot_s   = a_s / b_s;
   assign rem_s    = a_s % b_s;
   assign quot_u   = a / b_safe;
   assign rem_u    = a % b_safe;

   always_comb begin
      hi_n  = 32'd0;
      lo_n  = 32'd0;
      wr_en = 1'b0;
      unique case (op_e)
         MD_MULT: begin
            {hi_n, lo_n} = prod_s;
            wr_en        = 1'b1;
         end
         MD_MULTU: begin
            {hi_n, lo_n} = prod_u;
            wr_en        = 1'b1;
         end
         MD_DIV: begin
            lo_n  = div_ovf ? INT_MIN : quot_s;
            hi_n  = div_ovf ? 32'd0 : rem_s;
            wr_en = !div_zero;
         end
         MD_DIVU: begin
            lo_n  = quot_u;
            hi_n  = rem_u;
            wr_en = !div_zero;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide sequencer: owns HI/LO, models iterative latency, reports busy to the hazard unit.
module md_sched
   import md_sched_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int CNT_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      hi_q, hi_d, lo_q, lo_d;
   logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
   logic             pend_wr_q, pend_wr_d;
   logic [31:0]      hi_n, lo_n;
   logic             wr_en;
   md_op_e           op_e;

   assign op_e = md_op_e'(op);

   md_sched_calc u_calc (
      .op    (op),
      .a     (a),
      .b     (b),
      .hi_n  (hi_n),
      .lo_n  (lo_n),
      .wr_en (wr_en)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_wr_d = pend_wr_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               unique case (op_e)
                  MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                     pend_hi_d = hi_n;
                     pend_lo_d = lo_n;
                     pend_wr_d = wr_en;
                     cnt_d     = (op_e == MD_DIV || op_e == MD_DIVU) ? DIV_LOAD : MULT_LOAD;
                     state_d   = ST_RUN;
                  end
                  MD_MTHI: hi_d = a;
                  MD_MTLO: lo_d = a;
                  default: ;
               endcase
            end
         end
         ST_RUN: begin
            // Commands arriving here are dropped; the hazard unit must never issue them.
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               if (pend_wr_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         pend_wr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_wr_q <= pend_wr_d;
      end
   end

   assign busy = (state_q == ST_RUN);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
